// File: rtl/commit_pkg.sv
// Shared types and store-lane helpers for the commit scheduler.
package commit_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [5:0]  ard;
        logic [31:0] data;
        logic        is_store;
        logic [31:0] st_addr;
        logic [31:0] st_data;
    } commit_entry_t;

    typedef enum logic [0:0] {IDLE, ST_WAIT} cs_state_e;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    function automatic logic [3:0] st_wstrb_f(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_SB:   return 4'b0001 << off;
            F3_SH:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Sub-word stores are moved onto their byte lanes; word stores ignore the offset.
    function automatic logic [31:0] st_shift_f(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] data);
        if (f3 == F3_SB || f3 == F3_SH) return data << {off, 3'b000};
        return data;
    endfunction

endpackage

// File: rtl/commit_fifo.sv
// Two-write / one-read in-order buffer for retiring entries, with flush that can spare the head.
module commit_fifo
    import commit_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_two,
    input  commit_entry_t wr_data0,
    input  commit_entry_t wr_data1,
    input  logic          rd_en,
    input  logic          flush,
    input  logic          keep_head,
    output commit_entry_t head,
    output logic [CW-1:0] count
);

    commit_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [1:0]    n_wr;
    logic          do_wr;

    assign do_wr  = wr_en && !flush;
    assign n_wr   = do_wr ? (wr_two ? 2'd2 : 2'd1) : 2'd0;
    assign rd_nxt = rd_ptr + AW'(rd_en);
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data0;
            if (wr_two) mem[wr_ptr + AW'(1)] <= wr_data1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= rd_nxt;
            // An in-flight store at the head survives the flush unless it retires this edge.
            if (keep_head && !rd_en) begin
                wr_ptr <= rd_ptr + AW'(1);
                count  <= CW'(1);
            end else begin
                wr_ptr <= rd_nxt;
                count  <= '0;
            end
        end else begin
            rd_ptr <= rd_nxt;
            wr_ptr <= wr_ptr + AW'(n_wr);
            count  <= count + CW'(n_wr) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/commit_scheduler.sv
// Dual-lane retire buffer feeding a single in-order commit port; stores drain via req/ack first.
// Optional performance counters are built only when COMMIT_PERF_EN is defined.
module commit_scheduler
    import commit_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       rob_valid,
    input  logic [1:0][31:0] rob_pc,
    input  logic [1:0][31:0] rob_inst,
    input  logic [1:0][5:0]  rob_ard,
    input  logic [1:0][31:0] rob_data,
    input  logic [1:0]       rob_is_store,
    input  logic [1:0][31:0] rob_st_addr,
    input  logic [1:0][31:0] rob_st_data,
    output logic             rob_ready,
    input  logic             flush,
    output logic             st_req,
    output logic [31:0]      st_addr_o,
    output logic [31:0]      st_wdata,
    output logic [3:0]       st_wstrb,
    input  logic             st_ack,
    output logic             commit_valid,
    output logic [31:0]      commit_pc,
    output logic [31:0]      commit_inst,
    output logic [31:0]      commit_data,
    output logic [5:0]       commit_Ard,
    output logic             st_commit,
    output logic [31:0]      st_addr,
    output logic [31:0]      st_data,
    output logic [31:0]      perf_commits,
    output logic [31:0]      perf_st_stall
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    commit_entry_t   lane0, lane1, head;
    cs_state_e       state;
    logic [CW-1:0]   count;
    logic            empty, pop;
    logic [2:0]      f3;
    logic [1:0]      off;

    assign lane0 = '{pc: rob_pc[0], inst: rob_inst[0], ard: rob_ard[0], data: rob_data[0],
                     is_store: rob_is_store[0], st_addr: rob_st_addr[0],
                     st_data: rob_st_data[0]};
    assign lane1 = '{pc: rob_pc[1], inst: rob_inst[1], ard: rob_ard[1], data: rob_data[1],
                     is_store: rob_is_store[1], st_addr: rob_st_addr[1],
                     st_data: rob_st_data[1]};

    assign rob_ready = !rst && (count <= CW'(DEPTH - 2));
    assign empty     = (count == '0);
    assign f3        = head.inst[14:12];
    assign off       = head.st_addr[1:0];
    assign pop       = ((state == IDLE) && !empty && !flush && !head.is_store) ||
                       ((state == ST_WAIT) && st_ack);

    commit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (rob_valid[0] && rob_ready),
        .wr_two    (rob_valid[1]),
        .wr_data0  (lane0),
        .wr_data1  (lane1),
        .rd_en     (pop),
        .flush     (flush),
        .keep_head (state == ST_WAIT),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            st_req       <= 1'b0;
            st_addr_o    <= '0;
            st_wdata     <= '0;
            st_wstrb     <= '0;
            commit_valid <= 1'b0;
            commit_pc    <= '0;
            commit_inst  <= '0;
            commit_data  <= '0;
            commit_Ard   <= '0;
            st_commit    <= 1'b0;
            st_addr      <= '0;
            st_data      <= '0;
        end else begin
            commit_valid <= 1'b0;
            st_commit    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty && !flush) begin
                        if (head.is_store) begin
                            st_req    <= 1'b1;
                            st_addr_o <= {head.st_addr[31:2], 2'b00};
                            st_wdata  <= st_shift_f(f3, off, head.st_data);
                            st_wstrb  <= st_wstrb_f(f3, off);
                            state     <= ST_WAIT;
                        end else begin
                            commit_valid <= 1'b1;
                            commit_pc    <= head.pc;
                            commit_inst  <= head.inst;
                            commit_data  <= head.data;
                            commit_Ard   <= head.ard;
                            st_addr      <= '0;
                            st_data      <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (st_ack) begin
                        st_req       <= 1'b0;
                        commit_valid <= 1'b1;
                        st_commit    <= 1'b1;
                        commit_pc    <= head.pc;
                        commit_inst  <= head.inst;
                        commit_data  <= head.data;
                        commit_Ard   <= '0;
                        st_addr      <= head.st_addr;
                        st_data      <= st_wdata;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef COMMIT_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_commits  <= '0;
            perf_st_stall <= '0;
        end else begin
            if (commit_valid) perf_commits <= perf_commits + 32'd1;
            if (state == ST_WAIT) perf_st_stall <= perf_st_stall + 32'd1;
        end
    end
`else
    assign perf_commits  = '0;
    assign perf_st_stall = '0;
`endif

endmodule

// File: tb/tb_commit_scheduler.sv
// Scoreboard bench for commit_scheduler: directed retire patterns, stores, fill, flush, reset.
module tb_commit_scheduler;
    import commit_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       rob_valid = '0;
    logic [1:0][31:0] rob_pc = '0, rob_inst = '0, rob_data = '0, rob_st_addr = '0, rob_st_data = '0;
    logic [1:0][5:0]  rob_ard = '0;
    logic [1:0]       rob_is_store = '0;
    logic             rob_ready, flush = 1'b0, st_ack = 1'b0;
    logic             st_req, commit_valid, st_commit;
    logic [31:0]      st_addr_o, st_wdata, commit_pc, commit_inst, commit_data;
    logic [31:0]      st_addr, st_data, perf_commits, perf_st_stall;
    logic [3:0]       st_wstrb;
    logic [5:0]       commit_Ard;

    commit_scheduler #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .rob_valid(rob_valid), .rob_pc(rob_pc), .rob_inst(rob_inst),
        .rob_ard(rob_ard), .rob_data(rob_data), .rob_is_store(rob_is_store),
        .rob_st_addr(rob_st_addr), .rob_st_data(rob_st_data), .rob_ready(rob_ready),
        .flush(flush), .st_req(st_req), .st_addr_o(st_addr_o), .st_wdata(st_wdata),
        .st_wstrb(st_wstrb), .st_ack(st_ack), .commit_valid(commit_valid),
        .commit_pc(commit_pc), .commit_inst(commit_inst), .commit_data(commit_data),
        .commit_Ard(commit_Ard), .st_commit(st_commit), .st_addr(st_addr), .st_data(st_data),
        .perf_commits(perf_commits), .perf_st_stall(perf_st_stall)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] pc, inst, data, sa, sd;
        logic [5:0]  ard;
        logic        st;
        int          c;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    localparam logic [31:0] I_ALU = 32'h00a28293;
    localparam logic [31:0] I_SB  = 32'h00000023;
    localparam logic [31:0] I_SH  = 32'h00001023;
    localparam logic [31:0] I_SW  = 32'h00002023;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    function automatic commit_entry_t mk(input logic [31:0] pc, input logic [31:0] inst,
                                         input logic [5:0] ard, input logic [31:0] data,
                                         input logic st, input logic [31:0] sa,
                                         input logic [31:0] sd);
        commit_entry_t e;
        e.pc = pc; e.inst = inst; e.ard = ard; e.data = data;
        e.is_store = st; e.st_addr = sa; e.st_data = sd;
        return e;
    endfunction

    task automatic drive(input logic [1:0] v, input commit_entry_t e0, input commit_entry_t e1);
        rob_valid = v;
        rob_pc[0] = e0.pc;             rob_pc[1] = e1.pc;
        rob_inst[0] = e0.inst;         rob_inst[1] = e1.inst;
        rob_ard[0] = e0.ard;           rob_ard[1] = e1.ard;
        rob_data[0] = e0.data;         rob_data[1] = e1.data;
        rob_is_store[0] = e0.is_store; rob_is_store[1] = e1.is_store;
        rob_st_addr[0] = e0.st_addr;   rob_st_addr[1] = e1.st_addr;
        rob_st_data[0] = e0.st_data;   rob_st_data[1] = e1.st_data;
    endtask

    task automatic expect_c(input commit_entry_t e, input logic [5:0] ard, input logic st,
                            input logic [31:0] sa, input logic [31:0] sd, input int c);
        q.push_back('{pc: e.pc, inst: e.inst, data: e.data, sa: sa, sd: sd, ard: ard, st: st,
                      c: c});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 30 && q.size() != 0; i++) step();
        chk({nm, "_pending"}, 32'(q.size()), 32'd0);
    endtask

    // Single store: checks the D-mem request while held, acks after dly cycles of st_req.
    task automatic run_store(input string nm, input commit_entry_t e, input logic [31:0] aaddr,
                             input logic [3:0] strb, input logic [31:0] wdata, input int dly);
        int n;
        drive(2'b01, e, '0);
        step();
        drive(2'b00, '0, '0);
        n = cyc;
        @(negedge clk);
        chk({nm, "_req_early"}, 32'(st_req), 32'd0);
        for (int k = 1; k <= dly; k++) begin
            @(negedge clk);
            chk({nm, "_req_held"}, 32'(st_req), 32'd1);
            chk({nm, "_wstrb"}, 32'(st_wstrb), 32'(strb));
            chk({nm, "_wdata"}, st_wdata, wdata);
            chk({nm, "_addr"}, st_addr_o, aaddr);
        end
        expect_c(e, 6'd0, 1'b1, e.st_addr, wdata, n + 1 + dly);
        st_ack = 1'b1;
        @(negedge clk);
        st_ack = 1'b0;
        chk({nm, "_req_drop"}, 32'(st_req), 32'd0);
        step();
    endtask

    // Monitor: every commit pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (commit_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit: got pc %h, required no commit", commit_pc);
                end else begin
                    e = q.pop_front();
                    chk("commit_pc", commit_pc, e.pc);
                    chk("commit_inst", commit_inst, e.inst);
                    chk("commit_data", commit_data, e.data);
                    chk("commit_Ard", 32'(commit_Ard), 32'(e.ard));
                    chk("st_commit", 32'(st_commit), 32'(e.st));
                    chk("st_addr", st_addr, e.sa);
                    chk("st_data", st_data, e.sd);
                    if (e.c >= 0) chk("commit_cycle", 32'(cyc), 32'(e.c));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        commit_entry_t a, b, s, x0, x1, c0, c1;
        int n;

        // Reset state
        #12;
        chk("rst_st_req", 32'(st_req), 32'd0);
        chk("rst_commit_valid", 32'(commit_valid), 32'd0);
        chk("rst_rob_ready", 32'(rob_ready), 32'd0);
        chk("rst_perf_commits", perf_commits, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rob_ready", 32'(rob_ready), 32'd1);
        step();

        // 1: ALU pair, commits on consecutive cycles in program order
        a = mk(32'h2000, I_ALU, 6'd5, 32'h11, 1'b0, '0, '0);
        b = mk(32'h2004, I_ALU, 6'd6, 32'h22, 1'b0, '0, '0);
        drive(2'b11, a, b);
        step();
        drive(2'b00, '0, '0);
        n = cyc;
        expect_c(a, 6'd5, 1'b0, '0, '0, n + 1);
        expect_c(b, 6'd6, 1'b0, '0, '0, n + 2);
        drain("alu_pair");

        // Stray ack with no request outstanding
        st_ack = 1'b1;
        step();
        st_ack = 1'b0;
        chk("stray_ack_req", 32'(st_req), 32'd0);

        // 2: SB at byte offset 3, ack after 3 cycles
        s = mk(32'h2100, I_SB, 6'd7, 32'h99, 1'b1, 32'h1003, 32'hAB);
        run_store("sb", s, 32'h1000, 4'b1000, 32'hAB000000, 3);
`ifdef COMMIT_PERF_EN
        chk("perf_st_stall", perf_st_stall, 32'd3);
`else
        chk("perf_st_stall", perf_st_stall, 32'd0);
`endif

        // 3: SH upper half, SW
        s = mk(32'h2104, I_SH, 6'd0, 32'h0, 1'b1, 32'h1002, 32'h1234);
        run_store("sh", s, 32'h1000, 4'b1100, 32'h12340000, 1);
        s = mk(32'h2108, I_SW, 6'd0, 32'h0, 1'b1, 32'h1004, 32'hDEADBEEF);
        run_store("sw", s, 32'h1004, 4'b1111, 32'hDEADBEEF, 2);
`ifdef COMMIT_PERF_EN
        chk("perf_commits", perf_commits, 32'd5);
`else
        chk("perf_commits", perf_commits, 32'd0);
`endif

        // 4: fill while the store waits; blocked pushes must not write
        s  = mk(32'h3000, I_SW, 6'd9, 32'h0, 1'b1, 32'h3000, 32'h0BADF00D);
        a  = mk(32'h3004, I_ALU, 6'd1, 32'hA1, 1'b0, '0, '0);
        b  = mk(32'h3008, I_ALU, 6'd2, 32'hA2, 1'b0, '0, '0);
        c0 = mk(32'h300C, I_ALU, 6'd3, 32'hA3, 1'b0, '0, '0);
        x0 = mk(32'hBAD0, I_ALU, 6'd30, 32'hEE, 1'b0, '0, '0);
        x1 = mk(32'hBAD4, I_ALU, 6'd31, 32'hFF, 1'b0, '0, '0);
        drive(2'b11, s, a);
        step();
        chk("fill_ready_half", 32'(rob_ready), 32'd1);
        drive(2'b11, b, c0);
        step();
        chk("fill_ready_full", 32'(rob_ready), 32'd0);
        chk("fill_st_req", 32'(st_req), 32'd1);
        drive(2'b11, x0, x1);
        step();
        step();
        chk("fill_ready_hold", 32'(rob_ready), 32'd0);
        drive(2'b00, '0, '0);
        expect_c(s, 6'd0, 1'b1, 32'h3000, 32'h0BADF00D, -1);
        expect_c(a, 6'd1, 1'b0, '0, '0, -1);
        expect_c(b, 6'd2, 1'b0, '0, '0, -1);
        expect_c(c0, 6'd3, 1'b0, '0, '0, -1);
        st_ack = 1'b1;
        step();
        st_ack = 1'b0;
        drain("fill");
        chk("fill_ready_after", 32'(rob_ready), 32'd1);

        // 5: flush in ST_WAIT with three queued, plus a simultaneous push that must drop
        s = mk(32'h4000, I_SB, 6'd4, 32'h0, 1'b1, 32'h4001, 32'h5A);
        drive(2'b11, s, a);
        step();
        drive(2'b11, b, c0);
        step();
        chk("flush_st_req", 32'(st_req), 32'd1);
        flush = 1'b1;
        drive(2'b11, x0, x1);
        step();
        flush = 1'b0;
        drive(2'b00, '0, '0);
        chk("flush_st_req_kept", 32'(st_req), 32'd1);
        chk("flush_wdata", st_wdata, 32'h00005A00);
        chk("flush_wstrb", 32'(st_wstrb), 32'h2);
        step();
        expect_c(s, 6'd0, 1'b1, 32'h4001, 32'h00005A00, -1);
        st_ack = 1'b1;
        step();
        st_ack = 1'b0;
        drain("flush");
        repeat (5) step();
        c0 = mk(32'h5000, I_ALU, 6'd10, 32'h50, 1'b0, '0, '0);
        c1 = mk(32'h5004, I_ALU, 6'd11, 32'h51, 1'b0, '0, '0);
        drive(2'b11, c0, c1);
        step();
        drive(2'b00, '0, '0);
        // Ready after one pair proves the flush left nothing behind
        chk("flush_empty_ready", 32'(rob_ready), 32'd1);
        expect_c(c0, 6'd10, 1'b0, '0, '0, -1);
        expect_c(c1, 6'd11, 1'b0, '0, '0, -1);
        drain("post_flush");

        // 6: async reset while a store is outstanding
        s = mk(32'h6000, I_SW, 6'd0, 32'h0, 1'b1, 32'h6000, 32'h66);
        drive(2'b01, s, '0);
        step();
        drive(2'b00, '0, '0);
        step();
        chk("rst_mid_req_before", 32'(st_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_req_drop", 32'(st_req), 32'd0);
        chk("rst_mid_commit", 32'(commit_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", 32'(rob_ready), 32'd1);
        chk("rst_mid_perf", perf_commits, 32'd0);
        repeat (6) step();
        chk("rst_mid_req_idle", 32'(st_req), 32'd0);
        chk("end_pending", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
